nvme_irq_coalesce: RTL

Parametrised per-vector interrupt aggregation engine for the NVMe controller, placed between the completion-queue managers and the PCIe interrupt generator (`pcie_irq_gen`). It supports a configurable number of completion queues and MSI/MSI-X vectors, and implements NVMe Interrupt Coalescing: Feature 08h aggregation threshold and time, and Feature 09h per-vector coalescing disable. It emits one interrupt request at a time to the generator over a req/ack handshake, using round-robin arbitration across ready vectors.

---
 rtl/nvme_irq_coalesce.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/nvme_irq_coalesce.sv
// ---------------------------------------------------------------------------
// nvme_irq_coalesce
//
// Per-vector NVMe interrupt coalescing engine. It sits between the
// completion-queue managers and the PCIe interrupt generator. Each vector
// counts posted completions and measures the time since its first
// un-signalled completion. When a vector's threshold or time limit is
// reached, or when coalescing does not apply to it (admin vector 0 and
// vectors with coalescing disabled), the vector becomes pending. Unmasked
// pending vectors are then granted one at a time, in round-robin order,
// over a req/ack handshake.
//
// Ports:
//   pcie_user_clk / pcie_user_rst : clock, synchronous active-high reset
//   cq_valid, cq_irq_en           : per-CQ created / interrupt-enable flags
//   cq_iv                         : packed vector number per CQ (CQ0 -> vector 0)
//   cq_tail_ptr, cq_head_ptr      : packed per-CQ tail / host head pointers
//   cq_tail_update                : per-CQ pulse, one completion posted
//   cq_head_update                : per-CQ pulse, host head doorbell write
//   aggr_thr, aggr_time           : zero-based threshold, time limit (0 = off)
//   iv_cd, iv_mask                : per-vector coalescing disable / mask
//   irq_req, irq_vector, irq_ack  : request handshake to the interrupt generator
//   irq_pending                   : per-vector "armed and fire condition met"
// ---------------------------------------------------------------------------
module nvme_irq_coalesce #(
  parameter int C_NUM_CQ           = 9,
  parameter int C_NUM_IV           = 8,
  parameter int C_IV_WIDTH         = 3,
  parameter int C_PTR_WIDTH        = 8,
  parameter int C_TIME_UNIT_CYCLES = 25000
) (
  input  logic                            pcie_user_clk,
  input  logic                            pcie_user_rst,
  input  logic [C_NUM_CQ-1:0]             cq_valid,
  input  logic [C_NUM_CQ-1:0]             cq_irq_en,
  input  logic [C_NUM_CQ*C_IV_WIDTH-1:0]  cq_iv,
  input  logic [C_NUM_CQ*C_PTR_WIDTH-1:0] cq_tail_ptr,
  input  logic [C_NUM_CQ*C_PTR_WIDTH-1:0] cq_head_ptr,
  input  logic [C_NUM_CQ-1:0]             cq_tail_update,
  input  logic [C_NUM_CQ-1:0]             cq_head_update,
  input  logic [7:0]                      aggr_thr,
  input  logic [7:0]                      aggr_time,
  input  logic [C_NUM_IV-1:0]             iv_cd,
  input  logic [C_NUM_IV-1:0]             iv_mask,
  output logic                            irq_req,
  output logic [C_IV_WIDTH-1:0]           irq_vector,
  input  logic                            irq_ack,
  output logic [C_NUM_IV-1:0]             irq_pending
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam int PRE_W = (C_TIME_UNIT_CYCLES > 1) ? $clog2(C_TIME_UNIT_CYCLES) : 1;
  // Wide enough for 255 plus one pulse per CQ in the same cycle.
  localparam int INC_W = 16;

  state_t                 state_q, state_d;
  logic [C_IV_WIDTH-1:0]  last_grant;
  logic [PRE_W-1:0]       prescale;
  logic                   tick;
  logic                   ack_take;

  logic [C_NUM_CQ-1:0]    cq_elig;
  logic [C_NUM_CQ-1:0]    cq_ne;
  logic [C_IV_WIDTH-1:0]  cq_vec [C_NUM_CQ];

  logic [C_NUM_IV-1:0]    armed_d, armed_q;
  logic [INC_W-1:0]       inc     [C_NUM_IV];
  logic [INC_W-1:0]       cnt_sum [C_NUM_IV];
  logic [7:0]             agg_cnt [C_NUM_IV];
  logic [7:0]             cnt_d   [C_NUM_IV];
  logic [7:0]             agg_tmr [C_NUM_IV];
  logic [7:0]             tmr_d   [C_NUM_IV];
  logic [C_NUM_IV-1:0]    clr;
  logic [C_NUM_IV-1:0]    fire;
  logic [C_NUM_IV-1:0]    req_vec;
  logic [8:0]             thr_p1;

  logic                   grant_vld;
  logic [C_IV_WIDTH-1:0]  grant_idx;

  assign tick     = (prescale == PRE_W'(C_TIME_UNIT_CYCLES - 1));
  assign ack_take = (state_q == S_REQ) && irq_ack;
  assign irq_req  = (state_q == S_REQ);
  assign thr_p1   = {1'b0, aggr_thr} + 9'd1;

  // Per-CQ decode: eligibility, outstanding entries, and the target vector.
  always_comb begin
    for (int i = 0; i < C_NUM_CQ; i++) begin
      cq_elig[i] = cq_valid[i] & cq_irq_en[i];
      cq_ne[i]   = cq_tail_ptr[i*C_PTR_WIDTH +: C_PTR_WIDTH] !=
                   cq_head_ptr[i*C_PTR_WIDTH +: C_PTR_WIDTH];
      cq_vec[i]  = (i == 0) ? '0 : cq_iv[i*C_IV_WIDTH +: C_IV_WIDTH];
    end
  end

  // Head doorbells take effect only through the head pointers; the pulse
  // itself carries no extra information here.
  logic unused_head_update;
  assign unused_head_update = |cq_head_update;

  // Gather the armed flag and the number of new completions for each vector.
  // NOTE: every variable written in an always_comb gets a value first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int v = 0; v < C_NUM_IV; v++) begin
      armed_d[v] = 1'b0;
      inc[v]     = '0;
    end
    for (int v = 0; v < C_NUM_IV; v++) begin
      for (int i = 0; i < C_NUM_CQ; i++) begin
        if (cq_elig[i] && (cq_vec[i] == C_IV_WIDTH'(v))) begin
          armed_d[v] = armed_d[v] | cq_ne[i];
          inc[v]     = inc[v] + INC_W'(cq_tail_update[i]);
        end
      end
    end
  end

  // Counter / timer next state. A vector that is un-armed, or whose interrupt
  // is being acknowledged, restarts from zero; completions arriving in the
  // same cycle still count.
  always_comb begin
    for (int v = 0; v < C_NUM_IV; v++) begin
      clr[v]     = !armed_q[v] || (ack_take && (irq_vector == C_IV_WIDTH'(v)));
      cnt_sum[v] = (clr[v] ? '0 : INC_W'(agg_cnt[v])) + inc[v];
      cnt_d[v]   = (cnt_sum[v] > INC_W'(255)) ? 8'hFF : cnt_sum[v][7:0];
      tmr_d[v]   = agg_tmr[v];
      if (clr[v]) begin
        tmr_d[v] = '0;
      end else if (tick && (agg_cnt[v] != 8'd0) && (agg_tmr[v] != 8'hFF)) begin
        tmr_d[v] = agg_tmr[v] + 8'd1;
      end
    end
  end

  // Fire condition from registered state only.
  always_comb begin
    for (int v = 0; v < C_NUM_IV; v++) begin
      fire[v] = armed_q[v] && (agg_cnt[v] != 8'd0) &&
                ((v == 0) || iv_cd[v] ||
                 ({1'b0, agg_cnt[v]} >= thr_p1) ||
                 ((aggr_time != 8'd0) && (agg_tmr[v] >= aggr_time)));
    end
  end

  assign irq_pending = fire;
  assign req_vec     = fire & ~iv_mask;

  // Round-robin pick: first requester above last_grant, else the lowest one.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < C_NUM_IV; j++) begin
      if (!grant_vld && req_vec[j] && (C_IV_WIDTH'(j) > last_grant)) begin
        grant_vld = 1'b1;
        grant_idx = C_IV_WIDTH'(j);
      end
    end
    for (int j = 0; j < C_NUM_IV; j++) begin
      if (!grant_vld && req_vec[j]) begin
        grant_vld = 1'b1;
        grant_idx = C_IV_WIDTH'(j);
      end
    end
  end

  // Handshake FSM next state. A request, once raised, is held until acked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_REQ;
      S_REQ:   if (irq_ack)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      state_q    <= S_IDLE;
      irq_vector <= '0;
      last_grant <= C_IV_WIDTH'(C_NUM_IV - 1);
      prescale   <= '0;
      armed_q    <= '0;
      // NOTE: the per-vector counters and timers are live control state, not
      // storage, so they are reset like any other register.
      for (int v = 0; v < C_NUM_IV; v++) begin
        agg_cnt[v] <= '0;
        agg_tmr[v] <= '0;
      end
    end else begin
      state_q  <= state_d;
      prescale <= tick ? '0 : prescale + PRE_W'(1);
      armed_q  <= armed_d;
      for (int v = 0; v < C_NUM_IV; v++) begin
        agg_cnt[v] <= cnt_d[v];
        agg_tmr[v] <= tmr_d[v];
      end
      if ((state_q == S_IDLE) && grant_vld) begin
        irq_vector <= grant_idx;
      end
      if (ack_take) begin
        last_grant <= irq_vector;
      end
    end
  end

endmodule
